// File: rtl/cmd_pkg.sv
// -----------------------------------------------------------------------------
// cmd_pkg
// Constants and types for the TRS-80 /CMD format. Both the saver (write-out)
// and the download loader use them.
//   CMD_TYPE_DATA  : record type of a load block (type 01)
//   CMD_TYPE_XFER  : record type of the transfer-address block (type 02)
//   CMD_XFER_LEN   : LEN byte of the transfer block (always 2 address bytes)
//   CMD_MAX_BLOCK  : largest number of data bytes carried by one load block
//   saver_state_e  : state encoding of cmd_saver
//   cmd_len_byte() : LEN byte of a load block that carries n data bytes
// -----------------------------------------------------------------------------
package cmd_pkg;

   localparam logic [7:0] CMD_TYPE_DATA = 8'h01;
   localparam logic [7:0] CMD_TYPE_XFER = 8'h02;
   localparam logic [7:0] CMD_XFER_LEN  = 8'h02;
   localparam int         CMD_MAX_BLOCK = 256;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_HDR_TYPE  = 4'd1,
      ST_HDR_LEN   = 4'd2,
      ST_HDR_LSB   = 4'd3,
      ST_HDR_MSB   = 4'd4,
      ST_RD_REQ    = 4'd5,
      ST_RD_WAIT   = 4'd6,
      ST_DATA      = 4'd7,
      ST_XFER_TYPE = 4'd8,
      ST_XFER_LEN  = 4'd9,
      ST_XFER_LSB  = 4'd10,
      ST_XFER_MSB  = 4'd11
   } saver_state_e;

   // LEN counts the two address bytes plus the data bytes, modulo 256, so a
   // full 256-byte block encodes as 0x02 and a 254-byte block as 0x00.
   function automatic logic [7:0] cmd_len_byte(input logic [8:0] n);
      return n[7:0] + 8'd2;
   endfunction

endpackage

// File: rtl/cmd_saver.sv
// -----------------------------------------------------------------------------
// cmd_saver
// Serialises the RAM region [start_addr, end_addr] into a /CMD byte stream:
// type-01 load blocks of up to 256 data bytes, followed by one type-02
// transfer-address block that carries exec_addr.
//
// Ports
//   clock, reset         : system clock, synchronous active-high reset
//   start                : one-cycle save request (ignored while busy)
//   start_addr, end_addr : inclusive RAM range to save
//   exec_addr            : entry address placed in the type-02 block
//   mem_rd, mem_addr     : one-cycle RAM read strobe and its address
//   mem_ack, mem_data    : read data is valid on the cycle mem_ack is high
//   out_valid, out_ready : stream handshake
//   out_byte, out_last   : stream byte, last-byte marker
//   busy                 : save in progress
//   done                 : one-cycle pulse after the last byte is accepted
//   error                : one-cycle pulse when start has end_addr < start_addr
//   dbg_state            : current FSM state, for checkers
//
// Stream handshake: a byte transfers on every clock edge where out_valid and
// out_ready are both high. Once out_valid is raised, out_byte and out_last
// hold their value until the transfer happens; out_valid never drops without
// a transfer except on reset.
// -----------------------------------------------------------------------------
module cmd_saver
   import cmd_pkg::*;
#(
   parameter int DATA = 8,
   parameter int ADDR = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic [ADDR-1:0]    start_addr,
   input  logic [ADDR-1:0]    end_addr,
   input  logic [ADDR-1:0]    exec_addr,
   output logic               mem_rd,
   output logic [ADDR-1:0]    mem_addr,
   input  logic               mem_ack,
   input  logic [DATA-1:0]    mem_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA-1:0]    out_byte,
   output logic               out_last,
   output logic               busy,
   output logic               done,
   output logic               error,
   output saver_state_e       dbg_state
);

   saver_state_e    state_q, state_d;
   logic [ADDR-1:0] addr_q, addr_d;         // address of the next data byte
   logic [ADDR-1:0] exec_q, exec_d;
   logic [ADDR:0]   rem_q, rem_d;           // bytes still to emit, one bit wider
   logic [8:0]      blk_q, blk_d;           // bytes left in the current block
   logic [DATA-1:0] data_q, data_d;
   logic [ADDR-1:0] mem_addr_q, mem_addr_d;
   logic            done_q, done_d;
   logic            error_q, error_d;

   logic [8:0]      blk_n;                  // size of the block being headed
   logic            accept;

   // The header is emitted while rem_q still holds the count at block start,
   // so the block size can be derived from it directly.
   assign blk_n  = (rem_q >= (ADDR+1)'(CMD_MAX_BLOCK)) ? 9'(CMD_MAX_BLOCK)
                                                      : rem_q[8:0];
   assign accept = out_valid && out_ready;

   // ---------------------------------------------------------------- outputs
   always_comb begin
      out_valid = 1'b0;
      out_byte  = '0;
      out_last  = 1'b0;
      case (state_q)
         ST_HDR_TYPE:  begin out_valid = 1'b1; out_byte = CMD_TYPE_DATA;       end
         ST_HDR_LEN:   begin out_valid = 1'b1; out_byte = cmd_len_byte(blk_n); end
         ST_HDR_LSB:   begin out_valid = 1'b1; out_byte = addr_q[7:0];         end
         ST_HDR_MSB:   begin out_valid = 1'b1; out_byte = addr_q[15:8];        end
         ST_DATA:      begin out_valid = 1'b1; out_byte = data_q;              end
         ST_XFER_TYPE: begin out_valid = 1'b1; out_byte = CMD_TYPE_XFER;       end
         ST_XFER_LEN:  begin out_valid = 1'b1; out_byte = CMD_XFER_LEN;        end
         ST_XFER_LSB:  begin out_valid = 1'b1; out_byte = exec_q[7:0];         end
         ST_XFER_MSB:  begin
            out_valid = 1'b1;
            out_byte  = exec_q[15:8];
            out_last  = 1'b1;
         end
         default: ;
      endcase
   end

   assign mem_rd    = (state_q == ST_RD_REQ);
   assign mem_addr  = mem_addr_q;
   assign busy      = (state_q != ST_IDLE);
   assign done      = done_q;
   assign error     = error_q;
   assign dbg_state = state_q;

   // ------------------------------------------------------------- next state
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      exec_d     = exec_q;
      rem_d      = rem_q;
      blk_d      = blk_q;
      data_d     = data_q;
      mem_addr_d = mem_addr_q;
      done_d     = 1'b0;
      error_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (end_addr >= start_addr) begin
                  addr_d  = start_addr;
                  exec_d  = exec_addr;
                  rem_d   = {1'b0, end_addr} - {1'b0, start_addr} + (ADDR+1)'(1);
                  state_d = ST_HDR_TYPE;
               end else begin
                  error_d = 1'b1;
               end
            end
         end
         ST_HDR_TYPE: if (accept) state_d = ST_HDR_LEN;
         ST_HDR_LEN:  if (accept) state_d = ST_HDR_LSB;
         ST_HDR_LSB:  if (accept) state_d = ST_HDR_MSB;
         ST_HDR_MSB: begin
            if (accept) begin
               blk_d      = blk_n;
               mem_addr_d = addr_q;
               state_d    = ST_RD_REQ;
            end
         end
         ST_RD_REQ: state_d = ST_RD_WAIT;
         ST_RD_WAIT: begin
            if (mem_ack) begin
               data_d  = mem_data;
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (accept) begin
               // addr_q may wrap past the top of memory here, but mem_addr is
               // only reloaded when another read is actually issued.
               addr_d = addr_q + ADDR'(1);
               rem_d  = rem_q - (ADDR+1)'(1);
               blk_d  = blk_q - 9'd1;
               if (rem_q == (ADDR+1)'(1)) begin
                  state_d = ST_XFER_TYPE;
               end else if (blk_q == 9'd1) begin
                  state_d = ST_HDR_TYPE;
               end else begin
                  mem_addr_d = addr_q + ADDR'(1);
                  state_d    = ST_RD_REQ;
               end
            end
         end
         ST_XFER_TYPE: if (accept) state_d = ST_XFER_LEN;
         ST_XFER_LEN:  if (accept) state_d = ST_XFER_LSB;
         ST_XFER_LSB:  if (accept) state_d = ST_XFER_MSB;
         ST_XFER_MSB: begin
            if (accept) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // -------------------------------------------------------------- registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         exec_q     <= '0;
         rem_q      <= '0;
         blk_q      <= '0;
         data_q     <= '0;
         mem_addr_q <= '0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         exec_q     <= exec_d;
         rem_q      <= rem_d;
         blk_q      <= blk_d;
         data_q     <= data_d;
         mem_addr_q <= mem_addr_d;
         done_q     <= done_d;
         error_q    <= error_d;
      end
   end

endmodule
